// File: rtl/multi_dataflow_ctrl_fsm.sv
// Job sequencer for the multi_dataflow HWPE: clear, start, count output beats, signal done.
// Optional stall watchdog is compiled in with `define MULTI_DATAFLOW_FSM_WATCHDOG_EN.
module multi_dataflow_ctrl_fsm #(
  parameter int CNT_W       = 32,
  parameter int DIM_W       = 16,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trigger_i,
  input  logic [DIM_W-1:0] width_i,
  input  logic [DIM_W-1:0] height_i,
  input  logic             engine_ready_i,
  input  logic             out_hs_i,
  input  logic             src_done_i,
  output logic             engine_clear_o,
  output logic             engine_start_o,
  output logic             stream_in_start_o,
  output logic             stream_out_start_o,
  output logic             busy_o,
  output logic             evt_done_o,
  output logic             err_len_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] expected_len_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_src_sticky;
  logic               r_err_len;
  logic [2*DIM_W-1:0] w_prod;
  logic [CNT_W-1:0]   w_len;
  logic [CNT_W-1:0]   w_beat_inc;
  logic               w_accept;
  logic               w_at_len;
  logic               w_exit;
  logic               w_wdog_hit;
  logic               w_wdog_abort;

  assign w_prod     = {{DIM_W{1'b0}}, width_i} * {{DIM_W{1'b0}}, height_i};
  assign w_len      = CNT_W'(w_prod);
  assign w_accept   = (r_state == S_IDLE) && trigger_i && engine_ready_i;
  assign w_beat_inc = r_beat_cnt + CNT_W'(1);
  // The beat arriving this cycle may complete the job, so it counts toward the exit test.
  assign w_at_len   = (r_beat_cnt == r_len) || (out_hs_i && (w_beat_inc == r_len));
  assign w_exit     = (r_state == S_RUN) && w_at_len && (r_src_sticky || src_done_i);
  assign w_wdog_abort = (r_state == S_RUN) && !w_exit && w_wdog_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (w_len != '0)) w_next = S_CLEAR;
      S_CLEAR: w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN: begin
        if (w_exit)            w_next = S_DONE;
        else if (w_wdog_abort) w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_src_sticky <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_err_len <= w_accept && (w_len == '0);
      if (w_accept && (w_len != '0)) r_len <= w_len;
      if (r_state == S_CLEAR) begin
        r_beat_cnt   <= '0;
        r_src_sticky <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (out_hs_i && (r_beat_cnt != r_len)) r_beat_cnt <= w_beat_inc;
        if (src_done_i) r_src_sticky <= 1'b1;
      end
    end
  end

`ifdef MULTI_DATAFLOW_FSM_WATCHDOG_EN
  localparam int WCW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [WCW-1:0] r_stall;
  logic           r_timeout;

  assign w_wdog_hit = !out_hs_i && (r_stall == WCW'(WDOG_CYCLES - 1));

  // Stall counter restarts on RUN entry and on every accepted output beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wdog_abort;
      if (r_state == S_START || out_hs_i) r_stall <= '0;
      else if (r_state == S_RUN)          r_stall <= r_stall + WCW'(1);
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES == 0);
  assign w_wdog_hit    = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  assign engine_clear_o     = (r_state == S_CLEAR) || timeout_o;
  assign engine_start_o     = (r_state == S_START);
  assign stream_in_start_o  = (r_state == S_START);
  assign stream_out_start_o = (r_state == S_START);
  assign busy_o             = (r_state != S_IDLE);
  assign evt_done_o         = (r_state == S_DONE);
  assign err_len_o          = r_err_len;
  assign expected_len_o     = r_len;
  assign beat_cnt_o         = r_beat_cnt;

endmodule

// File: tb/tb_multi_dataflow_ctrl_fsm.sv
// Table-driven bench for multi_dataflow_ctrl_fsm with a done/error event scoreboard.
module tb_multi_dataflow_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [15:0] width;
  logic [15:0] height;
  logic        engine_ready;
  logic        out_hs;
  logic        src_done;
  logic        engine_clear, engine_start, stream_in_start, stream_out_start;
  logic        busy, evt_done, err_len, timeout;
  logic [31:0] expected_len, beat_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit is_err;
    int len;
    int beat;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int w;
    int h;
    int nb;
    int src_at;
    int done_at;
    bit err;
    int exp_len;
    int exp_beat;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  multi_dataflow_ctrl_fsm #(.CNT_W(32), .DIM_W(16), .WDOG_CYCLES(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .trigger_i         (trigger),
    .width_i           (width),
    .height_i          (height),
    .engine_ready_i    (engine_ready),
    .out_hs_i          (out_hs),
    .src_done_i        (src_done),
    .engine_clear_o    (engine_clear),
    .engine_start_o    (engine_start),
    .stream_in_start_o (stream_in_start),
    .stream_out_start_o(stream_out_start),
    .busy_o            (busy),
    .evt_done_o        (evt_done),
    .err_len_o         (err_len),
    .timeout_o         (timeout),
    .expected_len_o    (expected_len),
    .beat_cnt_o        (beat_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard: every done/error event must match the oldest expected record.
  always @(negedge clk) begin
    if (evt_done || err_len) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual done=%0b err=%0b required none", evt_done, err_len);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("evt_kind_err", {31'd0, err_len}, {31'd0, e.is_err});
        if (!e.is_err) begin
          chk("done_expected_len", expected_len, e.len);
          chk("done_beat_cnt", beat_cnt, e.beat);
          chk("done_busy", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic run_job(input vec_t v, input bit hold_trig);
    bit seen;
    seen    = 1'b0;
    width   = v.w[15:0];
    height  = v.h[15:0];
    trigger = 1'b1;
    q.push_back('{v.err, v.exp_len, v.exp_beat});
    step();
    trigger = 1'b0;
    if (v.err) begin
      chk("err_pulse", {31'd0, err_len}, 32'd1);
      chk("err_no_clear", {31'd0, engine_clear}, 32'd0);
      chk("err_busy", {31'd0, busy}, 32'd0);
      step();
      chk("err_one_cycle", {31'd0, err_len}, 32'd0);
      chk("err_no_start", {31'd0, engine_start}, 32'd0);
      chk("err_busy2", {31'd0, busy}, 32'd0);
      return;
    end
    chk("clear_t1", {31'd0, engine_clear}, 32'd1);
    chk("no_start_t1", {31'd0, engine_start}, 32'd0);
    chk("busy_t1", {31'd0, busy}, 32'd1);
    step();
    chk("clear_t2", {31'd0, engine_clear}, 32'd0);
    chk("starts_t2", {29'd0, engine_start, stream_in_start, stream_out_start}, 32'd7);
    step();
    chk("starts_off", {29'd0, engine_start, stream_in_start, stream_out_start}, 32'd0);
    trigger = hold_trig;
    for (int i = 0; i < v.nb; i++) begin
      out_hs   = 1'b1;
      src_done = (i == v.src_at);
      step();
      if (evt_done) seen = 1'b1;
      if (v.done_at >= 0) chk("done_latency", {31'd0, evt_done}, {31'd0, (i == v.done_at)});
      if (hold_trig) chk("mid_trig_no_clear", {30'd0, engine_clear, engine_start}, 32'd0);
    end
    out_hs   = 1'b0;
    src_done = 1'b0;
    trigger  = 1'b0;
    if (v.src_at >= v.nb && !seen) begin
      src_done = 1'b1;
      step();
      src_done = 1'b0;
      if (evt_done) seen = 1'b1;
    end
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (evt_done) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    step();
    if (evt_done) step();
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("done_once", {31'd0, evt_done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // {w, h, beats, src_done beat index (>=beats: after beats), done beat index or -1, err, len, beat_cnt}
    vt[0] = '{4, 2, 8, 8, -1, 1'b0, 8, 8};
    vt[1] = '{0, 5, 0, 0, -1, 1'b1, 0, 0};
    vt[2] = '{1, 3, 3, 0, 2, 1'b0, 3, 3};
    vt[3] = '{3, 1, 3, 2, 2, 1'b0, 3, 3};
    vt[4] = '{1, 3, 5, 0, 2, 1'b0, 3, 3};
    vt[5] = '{3, 1, 5, 5, -1, 1'b0, 3, 3};
    vt[6] = '{16, 16, 256, 100, 255, 1'b0, 256, 256};
    vt[7] = '{5, 0, 0, 0, -1, 1'b1, 0, 0};

    rst = 1'b1; trigger = 1'b0; width = '0; height = '0;
    engine_ready = 1'b1; out_hs = 1'b0; src_done = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {25'd0, engine_clear, engine_start, stream_in_start, stream_out_start,
                       evt_done, err_len, timeout}, 32'd0);
    chk("rst_len", expected_len, 32'd0);
    chk("rst_beat", beat_cnt, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_job(vt[i], 1'b0);

    // Trigger held through RUN is ignored; the next trigger starts a clean job.
    run_job('{2, 2, 4, 4, -1, 1'b0, 4, 4}, 1'b1);
    run_job('{3, 2, 6, 6, -1, 1'b0, 6, 6}, 1'b0);

    // Trigger while the engine is not ready waits and is not remembered.
    engine_ready = 1'b0;
    width = 16'd2; height = 16'd2; trigger = 1'b1;
    step(); step(); step();
    chk("notready_idle", {30'd0, busy, engine_clear}, 32'd0);
    trigger = 1'b0; engine_ready = 1'b1;
    step(); step();
    chk("notready_not_stored", {30'd0, busy, engine_clear}, 32'd0);

    // Reset in RUN aborts with no done event.
    width = 16'd4; height = 16'd2; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(); step();
    out_hs = 1'b1;
    step(); step();
    out_hs = 1'b0;
    chk("pre_rst_beats", beat_cnt, 32'd2);
    rst = 1'b1;
    step();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pulses", {25'd0, engine_clear, engine_start, stream_in_start, stream_out_start,
                          evt_done, err_len, timeout}, 32'd0);
    chk("midrst_len", expected_len, 32'd0);
    chk("midrst_beat", beat_cnt, 32'd0);
    rst = 1'b0;
    step();
    run_job('{4, 2, 8, 3, 7, 1'b0, 8, 8}, 1'b0);

    // Stall after 2 of 8 beats.
    width = 16'd8; height = 16'd1; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(); step();
    out_hs = 1'b1;
    step(); step();
    out_hs = 1'b0;
`ifdef MULTI_DATAFLOW_FSM_WATCHDOG_EN
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
        step();
        if (timeout) hit = 1'b1;
      end
      chk("wdog_timeout_seen", {31'd0, hit}, 32'd1);
      chk("wdog_clear", {31'd0, engine_clear}, 32'd1);
      chk("wdog_no_done", {31'd0, evt_done}, 32'd0);
      chk("wdog_idle", {31'd0, busy}, 32'd0);
      step();
      chk("wdog_one_cycle", {30'd0, timeout, engine_clear}, 32'd0);
    end
`else
    for (int k = 0; k < 40; k++) step();
    chk("nowdog_still_run", {31'd0, busy}, 32'd1);
    chk("nowdog_no_timeout", {30'd0, timeout, evt_done}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif
    run_job('{2, 3, 6, 6, -1, 1'b0, 6, 6}, 1'b0);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
